q_mcfifo: RTL and testbench

Parametrised multi-channel FIFO: N independent logical queues statically partitioned over one flop-array store, with one push and one pop per cycle, each addressed by channel. It supersedes the single-queue usage model with per-channel status, per-channel flush and error signalling. It sits between ingress arbitration and egress scheduling; status outputs feed the scheduler directly.

---
 rtl/q_mcfifo_pkg.sv | 26 ++
 rtl/q_mcfifo_chan.sv | 69 ++++++
 rtl/q_mcfifo.sv | 125 ++++++++++++
 tb/tb_q_mcfifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/q_mcfifo_pkg.sv
// Shared types, default configuration and helpers for the multi-channel FIFO.
// The typedefs describe the default geometry; the top re-derives its own widths from its parameters.
package q_mcfifo_pkg;

    localparam int unsigned DEF_W = 32;
    localparam int unsigned DEF_N = 4;
    localparam int unsigned DEF_D = 8;

    localparam int unsigned DEF_CHW = $clog2(DEF_N);
    localparam int unsigned DEF_PW  = $clog2(DEF_D);
    localparam int unsigned DEF_CW  = DEF_PW + 1;

    typedef logic [DEF_CHW-1:0] chan_t;
    typedef logic [DEF_PW-1:0]  ptr_t;
    typedef logic [DEF_CW-1:0]  cnt_t;

    // Occupancy counts are packed channel-major: channel c starts at bit c*cw.
    function automatic int unsigned occ_lsb(input int unsigned chan, input int unsigned cw);
        return chan * cw;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/q_mcfifo_chan.sv
// Book-keeping for one logical queue: read/write pointers and occupancy.
// Enables arrive already qualified by the top; flush overrides push and pop.
module q_mcfifo_chan
    import q_mcfifo_pkg::*;
#(
    parameter int unsigned D = DEF_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_en_i,
    input  logic                 pop_en_i,
    input  logic                 flush_en_i,
    output logic [$clog2(D)-1:0] rd_ptr_o,
    output logic [$clog2(D)-1:0] wr_ptr_o,
    output logic [$clog2(D):0]   cnt_o,
    output logic                 empty_o,
    output logic                 full_o
);

    localparam int unsigned PW = $clog2(D);
    localparam int unsigned CW = cnt_width(D);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // D is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_en_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_en_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_en_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_en_i && !pop_en_i) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop_en_i && !push_en_i) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_ptr_o = rd_ptr_q;
    assign wr_ptr_o = wr_ptr_q;
    assign cnt_o    = cnt_q;
    assign empty_o  = (cnt_q == '0);
    assign full_o   = (cnt_q == CW'(D));

endmodule

// File: rtl/q_mcfifo.sv
// N logical FIFOs statically partitioned over one flop array; one push and one pop per cycle.
// Channel c owns entries c*D .. c*D+D-1, so an entry address is simply {chan, ptr}.
module q_mcfifo
    import q_mcfifo_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned N = DEF_N,
    parameter int unsigned D = DEF_D
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_vld,
    input  logic [$clog2(N)-1:0]          push_chan,
    input  logic [W-1:0]                  push_data,
    output logic                          push_err,
    input  logic                          pop_vld,
    input  logic [$clog2(N)-1:0]          pop_chan,
    output logic                          pop_data_vld,
    output logic [W-1:0]                  pop_data,
    output logic                          pop_err,
    input  logic                          flush_vld,
    input  logic [$clog2(N)-1:0]          flush_chan,
    output logic [N-1:0]                  empty,
    output logic [N-1:0]                  full,
    output logic [N*($clog2(D)+1)-1:0]    occ
);

    localparam int unsigned CHW = $clog2(N);
    localparam int unsigned PW  = $clog2(D);
    localparam int unsigned CW  = cnt_width(D);

    logic [W-1:0]  mem_q [N*D];

    logic [PW-1:0] rd_ptr [N];
    logic [PW-1:0] wr_ptr [N];
    logic [CW-1:0] cnt    [N];

    logic [N-1:0]  push_en;
    logic [N-1:0]  pop_en;
    logic [N-1:0]  flush_en;

    logic          push_flushed, pop_flushed;
    logic          push_acc, push_rej;
    logic          pop_acc, pop_rej;

    logic [CHW+PW-1:0] wr_addr, rd_addr;

    logic          push_err_q, push_err_d;
    logic          pop_err_q, pop_err_d;
    logic          pop_data_vld_q, pop_data_vld_d;
    logic [W-1:0]  pop_data_q, pop_data_d;

    // Flush wins over push/pop on the same channel and silences them (no error).
    // Status comes from registered state only, so there is no same-cycle bypass.
    always_comb begin
        push_flushed = flush_vld && (flush_chan == push_chan);
        pop_flushed  = flush_vld && (flush_chan == pop_chan);
        push_acc     = !rst && push_vld && !full[push_chan] && !push_flushed;
        push_rej     = !rst && push_vld &&  full[push_chan] && !push_flushed;
        pop_acc      = !rst && pop_vld  && !empty[pop_chan] && !pop_flushed;
        pop_rej      = !rst && pop_vld  &&  empty[pop_chan] && !pop_flushed;
        wr_addr      = {push_chan, wr_ptr[push_chan]};
        rd_addr      = {pop_chan, rd_ptr[pop_chan]};
    end

    for (genvar c = 0; c < N; c++) begin : g_chan
        assign push_en[c]  = push_acc && (push_chan == CHW'(c));
        assign pop_en[c]   = pop_acc && (pop_chan == CHW'(c));
        assign flush_en[c] = !rst && flush_vld && (flush_chan == CHW'(c));

        q_mcfifo_chan #(
            .D (D)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .push_en_i  (push_en[c]),
            .pop_en_i   (pop_en[c]),
            .flush_en_i (flush_en[c]),
            .rd_ptr_o   (rd_ptr[c]),
            .wr_ptr_o   (wr_ptr[c]),
            .cnt_o      (cnt[c]),
            .empty_o    (empty[c]),
            .full_o     (full[c])
        );

        assign occ[occ_lsb(c, CW) +: CW] = cnt[c];
    end

    // Storage is deliberately not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_addr] <= push_data;
        end
    end

    always_comb begin
        push_err_d     = push_rej;
        pop_err_d      = pop_rej;
        pop_data_vld_d = pop_acc;
        pop_data_d     = pop_data_q;
        if (pop_acc) begin
            pop_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_err_q     <= 1'b0;
            pop_err_q      <= 1'b0;
            pop_data_vld_q <= 1'b0;
            pop_data_q     <= '0;
        end else begin
            push_err_q     <= push_err_d;
            pop_err_q      <= pop_err_d;
            pop_data_vld_q <= pop_data_vld_d;
            pop_data_q     <= pop_data_d;
        end
    end

    assign push_err     = push_err_q;
    assign pop_err      = pop_err_q;
    assign pop_data_vld = pop_data_vld_q;
    assign pop_data     = pop_data_q;

endmodule

// File: tb/tb_q_mcfifo.sv
// Directed bench for q_mcfifo (W=32, N=4, D=8): one table of per-cycle vectors,
// each with its inputs and the outputs expected after the following rising edge.
module tb_q_mcfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_vld;
    logic [1:0]  push_chan;
    logic [31:0] push_data;
    logic        push_err;
    logic        pop_vld;
    logic [1:0]  pop_chan;
    logic        pop_data_vld;
    logic [31:0] pop_data;
    logic        pop_err;
    logic        flush_vld;
    logic [1:0]  flush_chan;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [15:0] occ;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    q_mcfifo #(.W(32), .N(4), .D(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .push_vld     (push_vld),
        .push_chan    (push_chan),
        .push_data    (push_data),
        .push_err     (push_err),
        .pop_vld      (pop_vld),
        .pop_chan     (pop_chan),
        .pop_data_vld (pop_data_vld),
        .pop_data     (pop_data),
        .pop_err      (pop_err),
        .flush_vld    (flush_vld),
        .flush_chan   (flush_chan),
        .empty        (empty),
        .full         (full),
        .occ          (occ)
    );

    typedef struct {
        logic        rs;
        logic        pv;
        logic [1:0]  pc;
        logic [31:0] pd;
        logic        ov;
        logic [1:0]  oc;
        logic        fv;
        logic [1:0]  fc;
        logic        e_perr;
        logic        e_oerr;
        logic        e_ovld;
        logic [31:0] e_odata;
        logic [15:0] e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] occ4(input int o0, input int o1, input int o2, input int o3);
        return {4'(o3), 4'(o2), 4'(o1), 4'(o0)};
    endfunction

    task automatic add(input logic rs, input logic pv, input logic [1:0] pc, input logic [31:0] pd,
                       input logic ov, input logic [1:0] oc, input logic fv, input logic [1:0] fc,
                       input logic e_perr, input logic e_oerr, input logic e_ovld,
                       input logic [31:0] e_odata, input logic [15:0] e_occ);
        vec_t v;
        v.rs = rs; v.pv = pv; v.pc = pc; v.pd = pd; v.ov = ov; v.oc = oc; v.fv = fv; v.fc = fc;
        v.e_perr = e_perr; v.e_oerr = e_oerr; v.e_ovld = e_ovld; v.e_odata = e_odata; v.e_occ = e_occ;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        push_vld = 1'b0; push_chan = '0; push_data = '0;
        pop_vld = 1'b0; pop_chan = '0; flush_vld = 1'b0; flush_chan = '0;
    endtask

    initial begin
        logic [31:0] last_data;
        logic [3:0]  exp_empty, exp_full;

        // ---- clock / reset ----
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset occ", 32'(occ), 32'h0);
        chk("reset empty", 32'(empty), 32'hF);
        chk("reset full", 32'(full), 32'h0);
        chk("reset push_err", 32'(push_err), 32'h0);
        chk("reset pop_err", 32'(pop_err), 32'h0);
        chk("reset pop_data_vld", 32'(pop_data_vld), 32'h0);
        chk("reset pop_data", pop_data, 32'h0);

        // ---- vector table ----
        // Fill ch1, overflow, drain in order.
        for (int i = 0; i < 8; i++) add(0, 1, 1, 32'hA0 + i, 0, 0, 0, 0, 0, 0, 0, 0, occ4(0, i + 1, 0, 0));
        add(0, 1, 1, 32'hA8, 0, 0, 0, 0, 1, 0, 0, 0, occ4(0, 8, 0, 0));
        for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 32'hA0 + i, occ4(0, 7 - i, 0, 0));
        // Pop empty ch2 with same-cycle push: no forwarding.
        add(0, 1, 2, 32'hB0, 1, 2, 0, 0, 0, 1, 0, 0, occ4(0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 32'hB0, occ4(0, 0, 0, 0));
        // Full ch0 with same-cycle push+pop: push rejected, pop served.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 32'hC0 + i, 0, 0, 0, 0, 0, 0, 0, 0, occ4(i + 1, 0, 0, 0));
        add(0, 1, 0, 32'hC8, 1, 0, 0, 0, 1, 0, 1, 32'hC0, occ4(7, 0, 0, 0));
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hC1 + i, occ4(6 - i, 0, 0, 0));
        // Interleave ch0/ch3, then 20 push/pop pairs on ch3 across pointer wrap.
        add(0, 1, 0, 32'hD0, 0, 0, 0, 0, 0, 0, 0, 0, occ4(1, 0, 0, 0));
        add(0, 1, 3, 32'hE0, 0, 0, 0, 0, 0, 0, 0, 0, occ4(1, 0, 0, 1));
        add(0, 1, 0, 32'hD1, 0, 0, 0, 0, 0, 0, 0, 0, occ4(2, 0, 0, 1));
        for (int i = 0; i < 20; i++) add(0, 1, 3, 32'hE1 + i, 1, 3, 0, 0, 0, 0, 1, 32'hE0 + i, occ4(2, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hD0, occ4(1, 0, 0, 1));
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hD1, occ4(0, 0, 0, 1));
        add(0, 1, 2, 32'h55, 1, 3, 0, 0, 0, 0, 1, 32'hF4, occ4(0, 0, 1, 0));
        add(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 32'h55, occ4(0, 0, 0, 0));
        // Flush ch1 with same-cycle push and pop on ch1; ch2 untouched.
        for (int i = 0; i < 5; i++) add(0, 1, 1, 32'h10 + i, 0, 0, 0, 0, 0, 0, 0, 0, occ4(0, i + 1, 0, 0));
        for (int i = 0; i < 3; i++) add(0, 1, 2, 32'h20 + i, 0, 0, 0, 0, 0, 0, 0, 0, occ4(0, 5, i + 1, 0));
        add(0, 1, 1, 32'h99, 1, 1, 1, 1, 0, 0, 0, 0, occ4(0, 0, 3, 0));
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 32'h20 + i, occ4(0, 0, 2 - i, 0));
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, occ4(0, 0, 0, 0));
        // Reset mid-stream: 4 entries in ch0, pop plus other requests during reset.
        for (int i = 0; i < 4; i++) add(0, 1, 0, 32'h40 + i, 0, 0, 0, 0, 0, 0, 0, 0, occ4(i + 1, 0, 0, 0));
        add(0, 1, 1, 32'h66, 1, 0, 0, 0, 0, 0, 1, 32'h40, occ4(3, 1, 0, 0));
        add(1, 1, 2, 32'h77, 1, 0, 0, 0, 0, 0, 0, 0, occ4(0, 0, 0, 0));
        add(1, 1, 0, 32'h78, 1, 3, 0, 0, 0, 0, 0, 0, occ4(0, 0, 0, 0));
        add(0, 1, 1, 32'h88, 1, 0, 0, 0, 0, 1, 0, 0, occ4(0, 1, 0, 0));
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h88, occ4(0, 0, 0, 0));

        // ---- driver / scoreboard loop ----
        last_data = 32'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rs;
            push_vld  = vecs[i].pv;
            push_chan = vecs[i].pc;
            push_data = vecs[i].pd;
            pop_vld   = vecs[i].ov;
            pop_chan  = vecs[i].oc;
            flush_vld = vecs[i].fv;
            flush_chan = vecs[i].fc;
            @(negedge clk);
            if (vecs[i].rs) last_data = 32'h0;
            else if (vecs[i].e_ovld) last_data = vecs[i].e_odata;
            for (int c = 0; c < 4; c++) begin
                exp_empty[c] = (((vecs[i].e_occ >> (4 * c)) & 16'hF) == 16'd0);
                exp_full[c]  = (((vecs[i].e_occ >> (4 * c)) & 16'hF) == 16'd8);
            end
            chk($sformatf("v%0d push_err", i), 32'(push_err), 32'(vecs[i].e_perr));
            chk($sformatf("v%0d pop_err", i), 32'(pop_err), 32'(vecs[i].e_oerr));
            chk($sformatf("v%0d pop_data_vld", i), 32'(pop_data_vld), 32'(vecs[i].e_ovld));
            chk($sformatf("v%0d pop_data", i), pop_data, last_data);
            chk($sformatf("v%0d occ", i), 32'(occ), 32'(vecs[i].e_occ));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(exp_empty));
            chk($sformatf("v%0d full", i), 32'(full), 32'(exp_full));
        end
        rst = 1'b0;
        idle_inputs();

        // ---- report ----
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
